// File: rtl/axi4stream_input_buffer.sv
// Deserializes NUM_PACKETS AXI4-Stream beats (LSB-first) into one word; valid the cycle after the last beat.
// Backpressure: tready is held low while a word waits, so the source stalls until output_buffer_ready.
module axi4stream_input_buffer #(
   parameter int AXI_WIDTH         = 8,
   parameter int BUFFER_WIDTH      = 35,
   parameter int NUM_PACKETS       = 5,
   parameter int LAST_PACKET_WIDTH = 3
) (
   input  logic                    aclk,
   input  logic                    areset,
   input  logic [AXI_WIDTH-1:0]    tdata,
   input  logic                    tvalid,
   input  logic                    tlast,
   output logic                    tready,
   output logic [BUFFER_WIDTH-1:0] output_buffer,
   output logic                    output_buffer_valid,
   input  logic                    output_buffer_ready,
   output logic                    frame_error
);

   localparam int CNT_W = $clog2(NUM_PACKETS);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PACKETS - 1);

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      FULL    = 2'd1,
      DISCARD = 2'd2
   } state_t;

   state_t                  state, state_nxt;
   logic [CNT_W-1:0]        beat_count, count_nxt;
   logic [BUFFER_WIDTH-1:0] buf_nxt;
   logic                    err_nxt;
   logic                    accept;

   assign accept = tvalid && tready;

   always_ff @(posedge aclk) begin
      if (areset) begin
         state               <= COLLECT;
         beat_count          <= '0;
         tready              <= 1'b0;
         output_buffer       <= '0;
         output_buffer_valid <= 1'b0;
         frame_error         <= 1'b0;
      end else begin
         state               <= state_nxt;
         beat_count          <= count_nxt;
         tready              <= (state_nxt != FULL);
         output_buffer       <= buf_nxt;
         output_buffer_valid <= (state_nxt == FULL);
         frame_error         <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      count_nxt = beat_count;
      buf_nxt   = output_buffer;
      err_nxt   = 1'b0;
      case (state)
         COLLECT: begin
            if (accept) begin
               if (beat_count == LAST_CNT) begin
                  count_nxt = '0;
                  if (tlast) begin
                     // Final beat only carries LAST_PACKET_WIDTH meaningful bits.
                     buf_nxt[BUFFER_WIDTH-1 -: LAST_PACKET_WIDTH] = tdata[LAST_PACKET_WIDTH-1:0];
                     state_nxt = FULL;
                  end else begin
                     err_nxt   = 1'b1;
                     state_nxt = DISCARD;
                  end
               end else if (tlast) begin
                  err_nxt   = 1'b1;
                  count_nxt = '0;
               end else begin
                  for (int k = 0; k < NUM_PACKETS - 1; k++) begin
                     if (beat_count == CNT_W'(k)) begin
                        buf_nxt[k*AXI_WIDTH +: AXI_WIDTH] = tdata;
                     end
                  end
                  count_nxt = beat_count + 1'b1;
               end
            end
         end
         FULL: begin
            if (output_buffer_ready) begin
               state_nxt = COLLECT;
            end
         end
         DISCARD: begin
            // Drop beats until the source's own frame boundary to regain alignment.
            if (accept && tlast) begin
               state_nxt = COLLECT;
               count_nxt = '0;
            end
         end
         default: begin
            state_nxt = COLLECT;
            count_nxt = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_axi4stream_input_buffer.sv
// Randomized scoreboard bench for axi4stream_input_buffer with a word-level reference model.
module tb_axi4stream_input_buffer;

   localparam int AW  = 8;
   localparam int BW  = 35;
   localparam int NP  = 5;
   localparam int LPW = 3;

   logic          aclk = 1'b0;
   logic          areset = 1'b1;
   logic [AW-1:0] tdata = '0;
   logic          tvalid = 1'b0;
   logic          tlast = 1'b0;
   logic          tready;
   logic [BW-1:0] output_buffer;
   logic          output_buffer_valid;
   logic          output_buffer_ready = 1'b0;
   logic          frame_error;

   axi4stream_input_buffer #(
      .AXI_WIDTH(AW), .BUFFER_WIDTH(BW), .NUM_PACKETS(NP), .LAST_PACKET_WIDTH(LPW)
   ) dut (
      .aclk(aclk), .areset(areset), .tdata(tdata), .tvalid(tvalid), .tlast(tlast),
      .tready(tready), .output_buffer(output_buffer), .output_buffer_valid(output_buffer_valid),
      .output_buffer_ready(output_buffer_ready), .frame_error(frame_error)
   );

   always #5 aclk = ~aclk;

   int            checks = 0;
   int            errors = 0;
   int            err_seen = 0;
   int            exp_err = 0;
   int            ready_mode = 1;
   logic [BW-1:0] sb[$];
   logic          expect_tready = 1'b0;
   logic          was_valid = 1'b0;
   logic [BW-1:0] prev_buf = '0;

   logic [AW-1:0] nom[NP] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00};
   logic [AW-1:0] bp[NP]  = '{8'hBA, 8'hB0, 8'hFE, 8'hCA, 8'hF9};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Word value = sum of beats weighted by 2^(8k); final beat masked to LPW bits.
   function automatic logic [BW-1:0] pack(input logic [AW-1:0] b[NP]);
      logic [63:0] w = 64'd0;
      for (int k = 0; k < NP - 1; k++) w = w + (64'(b[k]) << (k * AW));
      w = w + ((64'(b[NP-1]) % (64'd1 << LPW)) << ((NP - 1) * AW));
      return w[BW-1:0];
   endfunction

   task automatic send_beat(input logic [AW-1:0] d, input logic l, input logic e,
                            input int glo, input int ghi, input logic fin);
      int gap = int'($urandom_range(ghi, glo));
      int budget = 0;
      repeat (gap) begin
         @(negedge aclk);
         tvalid = 1'b0;
      end
      @(negedge aclk);
      tvalid = 1'b1;
      tdata  = d;
      tlast  = l;
      while (!tready && budget < 500) begin
         @(negedge aclk);
         budget++;
      end
      if (!tready) begin
         chk("beat_accept_timeout", 64'(tready), 64'(1));
         tvalid = 1'b0;
         return;
      end
      @(posedge aclk);
      #1;
      tvalid = 1'b0;
      if (e) exp_err++;
      chk("frame_error_on_beat", 64'(frame_error), 64'(e));
      chk("valid_after_beat", 64'(output_buffer_valid), 64'(fin));
      if (fin) chk("tready_after_last", 64'(tready), 64'(0));
   endtask

   task automatic send_good(input logic [AW-1:0] b[NP], input int glo, input int ghi);
      sb.push_back(pack(b));
      for (int k = 0; k < NP; k++)
         send_beat(b[k], k == NP - 1, 1'b0, glo, ghi, k == NP - 1);
   endtask

   task automatic wait_drain();
      int b = 0;
      while (sb.size() != 0 && b < 2000) begin
         @(negedge aclk);
         b++;
      end
      chk("drain", 64'(sb.size()), 64'(0));
   endtask

   task automatic check_reset_outputs();
      chk("rst_tready", 64'(tready), 64'(0));
      chk("rst_valid", 64'(output_buffer_valid), 64'(0));
      chk("rst_buffer", 64'(output_buffer), 64'(0));
      chk("rst_frame_error", 64'(frame_error), 64'(0));
   endtask

   // Downstream consumer and output monitor.
   initial begin
      forever begin
         @(negedge aclk);
         if (!areset) begin
            if (expect_tready) begin
               chk("tready_after_consume", 64'(tready), 64'(1));
               chk("valid_after_consume", 64'(output_buffer_valid), 64'(0));
            end
            expect_tready = 1'b0;
            case (ready_mode)
               0:       output_buffer_ready = 1'($urandom_range(1, 0));
               1:       output_buffer_ready = 1'b1;
               default: output_buffer_ready = 1'b0;
            endcase
            if (frame_error) err_seen++;
            if (output_buffer_valid) begin
               chk("tready_while_full", 64'(tready), 64'(0));
               if (was_valid) chk("buffer_stable", 64'(output_buffer), 64'(prev_buf));
            end
            was_valid = output_buffer_valid;
            prev_buf  = output_buffer;
            if (output_buffer_valid && output_buffer_ready) begin
               if (sb.size() == 0) begin
                  chk("unexpected_word", 64'(output_buffer), 64'(0));
               end else begin
                  chk("word", 64'(output_buffer), 64'(sb.pop_front()));
               end
               expect_tready = 1'b1;
               was_valid     = 1'b0;
            end
         end
      end
   end

   initial begin
      logic [AW-1:0] rb[NP];
      int            kind, n;

      repeat (3) @(negedge aclk);
      check_reset_outputs();
      areset = 1'b0;
      @(negedge aclk);
      chk("tready_after_reset", 64'(tready), 64'(1));

      // Nominal word, back-to-back beats.
      ready_mode = 1;
      send_good(nom, 0, 0);
      wait_drain();

      // Masked last beat under held backpressure.
      ready_mode = 2;
      @(negedge aclk);
      send_good(bp, 0, 0);
      repeat (10) begin
         @(negedge aclk);
         chk("bp_valid_held", 64'(output_buffer_valid), 64'(1));
         chk("bp_tready_low", 64'(tready), 64'(0));
      end
      ready_mode = 1;
      wait_drain();

      // Early tlast, then a clean word.
      send_beat(8'h11, 1'b0, 1'b0, 0, 0, 1'b0);
      send_beat(8'h22, 1'b1, 1'b1, 0, 0, 1'b0);
      send_good(nom, 0, 0);
      wait_drain();

      // Missing tlast, junk until tlast, then a clean word.
      for (int k = 0; k < NP; k++) send_beat(nom[k], 1'b0, k == NP - 1, 0, 0, 1'b0);
      send_beat(8'h33, 1'b0, 1'b0, 0, 0, 1'b0);
      send_beat(8'h44, 1'b1, 1'b0, 0, 0, 1'b0);
      send_good(nom, 0, 0);
      wait_drain();

      // tvalid gaps between beats.
      send_good(nom, 1, 3);
      wait_drain();

      // Reset mid-word.
      for (int k = 0; k < 3; k++) send_beat(nom[k], 1'b0, 1'b0, 0, 0, 1'b0);
      @(negedge aclk);
      areset = 1'b1;
      @(negedge aclk);
      check_reset_outputs();
      areset = 1'b0;
      @(negedge aclk);
      chk("tready_after_midword_reset", 64'(tready), 64'(1));
      send_good(nom, 0, 0);
      wait_drain();

      // Random framing mix with random downstream readiness.
      ready_mode = 0;
      for (int f = 0; f < 200; f++) begin
         kind = int'($urandom_range(3, 0));
         for (int k = 0; k < NP; k++) rb[k] = AW'($urandom);
         if (kind <= 1) begin
            send_good(rb, 0, 2);
         end else if (kind == 2) begin
            n = int'($urandom_range(NP - 1, 1));
            for (int k = 0; k < n; k++)
               send_beat(rb[k], k == n - 1, k == n - 1, 0, 2, 1'b0);
         end else begin
            for (int k = 0; k < NP; k++)
               send_beat(rb[k], 1'b0, k == NP - 1, 0, 2, 1'b0);
            n = int'($urandom_range(3, 1));
            for (int k = 0; k < n; k++)
               send_beat(AW'($urandom), k == n - 1, 1'b0, 0, 2, 1'b0);
         end
      end
      ready_mode = 1;
      wait_drain();
      repeat (3) @(negedge aclk);

      chk("frame_error_count", 64'(err_seen), 64'(exp_err));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/axi4stream_input_buffer.md
# axi4stream_input_buffer

Deserializing AXI4-Stream sink: collects NUM_PACKETS beats of AXI_WIDTH bits into one BUFFER_WIDTH-bit word and presents it with a valid/ready handshake. It sits directly downstream of axi4stream_output_buffer, or of any AXI4-Stream source with the same framing, and rebuilds the wide word that stage serialized. It checks framing via tlast and resynchronizes on errors.

## Interface
- AXI_WIDTH, 8, stream beat width in bits
- BUFFER_WIDTH, 35, assembled word width; equals (NUM_PACKETS-1)*AXI_WIDTH + LAST_PACKET_WIDTH
- NUM_PACKETS, 5, beats per word (≥2)
- LAST_PACKET_WIDTH, 3, meaningful low bits of the final beat (1..AXI_WIDTH)

Ports:
- aclk  in  1  clock; all logic on rising edge
- areset  in  1  synchronous, active-high reset
- tdata  in  AXI_WIDTH  stream data
- tvalid  in  1  source has a beat
- tlast  in  1  marks final beat of a word
- tready  out  1  sink accepts a beat (registered)
- output_buffer  out  BUFFER_WIDTH  assembled word
- output_buffer_valid  out  1  output_buffer holds a complete word
- output_buffer_ready  in  1  downstream consumes the word
- frame_error  out  1  one-cycle pulse on a framing violation

## Operation
- Beat accepted ⇔ tvalid && tready at a rising edge.
- Packing is LSB-first. Beat k (0-based) writes output_buffer[k*AXI_WIDTH +: AXI_WIDTH] for k < NUM_PACKETS-1. The final beat writes only tdata[LAST_PACKET_WIDTH-1:0] into the top LAST_PACKET_WIDTH bits; its upper tdata bits are ignored.
- beat_count is $clog2(NUM_PACKETS) bits wide, counts 0..NUM_PACKETS-1, and returns to 0 after the final beat or after an error. It never wraps past NUM_PACKETS-1.
- States:
  - COLLECT: tready=1.
    - Accepted beat with beat_count < NUM_PACKETS-1 and tlast=0: store the beat, count+1.
    - Accepted beat with beat_count < NUM_PACKETS-1 and tlast=1 (early tlast): pulse frame_error, discard the partial word, count=0, stay in COLLECT.
    - Accepted beat with beat_count = NUM_PACKETS-1 and tlast=1: store the beat, count=0, go to FULL.
    - Accepted beat with beat_count = NUM_PACKETS-1 and tlast=0 (missing tlast): pulse frame_error, discard, go to DISCARD.
  - FULL: tready=0, output_buffer_valid=1, output_buffer stable. When output_buffer_ready=1, go to COLLECT.
  - DISCARD: tready=1. Drop every accepted beat. An accepted beat with tlast=1 returns to COLLECT with count=0.
- Partial contents of output_buffer during COLLECT/DISCARD are don't-care; output_buffer is only meaningful while output_buffer_valid=1.
- No data is lost while valid is high: tready stays 0 until the word is consumed.

## Timing
- Reset, sampled at an edge with areset=1, sets the following. This applies regardless of state, including mid-word or in FULL; partial data is dropped with no frame_error.
  - state = COLLECT, beat_count = 0
  - tready = 0
  - output_buffer = 0, output_buffer_valid = 0
  - frame_error = 0
- tready rises at the first edge with areset=0.
- Latency: output_buffer_valid rises at the edge that accepts the final beat, so it is visible the cycle after that beat. tready falls at the same edge.
- Consume: the edge with output_buffer_valid && output_buffer_ready clears valid and sets tready=1. The next beat can be accepted one cycle later.
- Minimum period per word: NUM_PACKETS + 1 cycles with ready held high (5 beats plus 1 handoff cycle).
- frame_error is registered and asserts for exactly one cycle, at the edge of the offending beat.
- tvalid gaps are allowed anywhere; an idle cycle changes nothing.

## Test plan
- Nominal: drive beats EF,BE,AD,DE,00 with tlast on the 5th, ready=1 → output_buffer=0x0DEADBEEF, valid on the cycle after beat 5, tready=0 for exactly 1 cycle.
- Last-beat masking plus backpressure: send BA,B0,FE,CA,F9 (tlast on F9), hold ready=0 for 10 cycles → output_buffer=0x1CAFEB0BA stable and tready=0 throughout; after ready, tready=1 next cycle.
- Early tlast: send 11,22 with tlast on 22, then the nominal word → one frame_error pulse, then 0x0DEADBEEF delivered correctly.
- Missing tlast: send 5 beats with no tlast, 2 junk beats (tlast on the 2nd), then the nominal word → one frame_error pulse, junk dropped, 0x0DEADBEEF delivered.
- tvalid gaps: insert 1–3 idle cycles between each nominal beat → same 0x0DEADBEEF result, no error.
- Reset mid-word: after 3 beats, assert areset for 1 cycle → all outputs 0 during reset, tready=1 next cycle; a fresh nominal word gives 0x0DEADBEEF with no frame_error.
